// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : MEM-stage load/store unit in front of a word-wide data
//                memory without byte enables. Loads are lane-extracted and
//                extended combinationally; SB/SH use a two-cycle
//                read-modify-write that stalls the pipeline for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              stall,
    output logic              fault,
    output logic              fault_sticky,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_wd,
    input  logic [31:0]       dm_rd
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_WRITE = 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [31:0]       r_merge;
    logic              r_fault_sticky;

    logic              w_idle;
    logic              w_store;
    logic              w_load;
    logic              w_illegal;
    logic              w_misalign;
    logic              w_fault;
    logic              w_sub_store;
    logic [ADDR_W-1:0] w_word_addr;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ext;
    logic [31:0]       w_merge;

    assign w_idle      = (r_state == c_IDLE);
    assign w_store     = mem_write;
    assign w_load      = mem_read & ~mem_write;
    assign w_word_addr = {addr[ADDR_W-1:2], 2'b00};

    // Request decode: illegal encodings and natural-alignment checks
    always_comb begin
        w_illegal = 1'b0;
        if (w_store)
            w_illegal = funct3[2] | (funct3[1:0] == 2'b11);
        else if (w_load)
            w_illegal = (funct3 == 3'b011) | (funct3 == 3'b110) | (funct3 == 3'b111);
        w_misalign = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

    // Faults are only reported while decoding; WRITE ignores the inputs
    assign w_fault     = rst_n & w_idle & (w_load | w_store) & (w_illegal | w_misalign);
    assign w_sub_store = w_idle & w_store & ~w_fault & ~funct3[1];

    // Load lane extraction and sign/zero extension
    always_comb begin
        w_byte = dm_rd[{addr[1:0], 3'b000} +: 8];
        w_half = addr[1] ? dm_rd[31:16] : dm_rd[15:0];
        case (funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b010:  w_ext = dm_rd;
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = 32'h0;
        endcase
    end

    // Merge the store byte/half into the word read this cycle
    always_comb begin
        w_merge = dm_rd;
        if (funct3[0] == 1'b0)
            w_merge[{addr[1:0], 3'b000} +: 8] = store_data[7:0];
        else
            w_merge[{addr[1], 4'b0000} +: 16] = store_data[15:0];
    end

    // Output drive; everything quiet while reset is held
    always_comb begin
        load_data = 32'h0;
        stall     = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = w_word_addr;
        dm_wd     = store_data;
        if (!w_idle) begin
            dm_addr = r_wr_addr;
            dm_wd   = r_merge;
            dm_we   = rst_n;
        end else if (rst_n && !w_fault) begin
            if (w_load)
                load_data = w_ext;
            if (w_store && funct3 == 3'b010)
                dm_we = 1'b1;
            stall = w_sub_store;
        end
    end

    assign fault        = w_fault;
    assign fault_sticky = r_fault_sticky;

    // FSM, read-modify-write capture and sticky fault flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= c_IDLE;
            r_wr_addr      <= '0;
            r_merge        <= 32'h0;
            r_fault_sticky <= 1'b0;
        end else begin
            if (w_fault)
                r_fault_sticky <= 1'b1;
            case (r_state)
                c_IDLE: begin
                    if (w_sub_store) begin
                        r_state   <= c_WRITE;
                        r_wr_addr <= w_word_addr;
                        r_merge   <= w_merge;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                small word-wide data memory model attached.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] load_data;
    logic        stall;
    logic        fault;
    logic        fault_sticky;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wd;
    logic [31:0] dm_rd;

    logic [31:0] mem [0:15];
    int          n_tests;
    int          n_fail;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .load_data    (load_data),
        .stall        (stall),
        .fault        (fault),
        .fault_sticky (fault_sticky),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wd        (dm_wd),
        .dm_rd        (dm_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: combinational read, write on rising edge
    assign dm_rd = mem[dm_addr[5:2]];
    always @(posedge clk) begin
        if (dm_we)
            mem[dm_addr[5:2]] <= dm_wd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    // Move to the sampling point of the current cycle
    task automatic mid;
        @(negedge clk);
    endtask

    // Move to just after the next rising edge
    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        rst_n = 1'b0;
        req(1'b0, 1'b1, 3'b010, 32'h4, 32'h1111_2222);

        // Reset: outputs quiet even with a store presented
        mid;
        chk("rst_we",    {31'h0, dm_we}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        req(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
        #1;
        chk("rst_fault", {31'h0, fault}, 32'h0);
        chk("rst_ld",    load_data, 32'h0);
        nxt;
        rst_n = 1'b1;
        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        mid;
        chk("idle_we",     {31'h0, dm_we}, 32'h0);
        chk("idle_ld",     load_data, 32'h0);
        chk("idle_sticky", {31'h0, fault_sticky}, 32'h0);
        nxt;

        // SW then loads of the same word
        req(1'b0, 1'b1, 3'b010, 32'h4, 32'hDEAD_BEEF);
        mid;
        chk("sw_we",    {31'h0, dm_we}, 32'h1);
        chk("sw_wd",    dm_wd, 32'hDEAD_BEEF);
        chk("sw_addr",  dm_addr, 32'h4);
        chk("sw_stall", {31'h0, stall}, 32'h0);
        nxt;
        req(1'b1, 1'b0, 3'b010, 32'h4, 32'h0); mid; chk("lw4",  load_data, 32'hDEAD_BEEF); nxt;
        req(1'b1, 1'b0, 3'b000, 32'h7, 32'h0); mid; chk("lb7",  load_data, 32'hFFFF_FFDE); nxt;
        req(1'b1, 1'b0, 3'b100, 32'h7, 32'h0); mid; chk("lbu7", load_data, 32'h0000_00DE); nxt;
        req(1'b1, 1'b0, 3'b001, 32'h6, 32'h0); mid; chk("lh6",  load_data, 32'hFFFF_DEAD); nxt;
        req(1'b1, 1'b0, 3'b101, 32'h4, 32'h0); mid; chk("lhu4", load_data, 32'h0000_BEEF); nxt;

        // SB 0x09 read-modify-write
        mem[2] = 32'h1234_5678;
        req(1'b0, 1'b1, 3'b000, 32'h9, 32'h0000_00AA);
        mid;
        chk("sb_stall", {31'h0, stall}, 32'h1);
        chk("sb_we0",   {31'h0, dm_we}, 32'h0);
        nxt;
        mid;
        chk("sb_we1",    {31'h0, dm_we}, 32'h1);
        chk("sb_stall1", {31'h0, stall}, 32'h0);
        chk("sb_wd",     dm_wd, 32'h1234_AA78);
        chk("sb_addr",   dm_addr, 32'h8);
        nxt;
        req(1'b1, 1'b0, 3'b010, 32'h8, 32'h0); mid; chk("lw8_sb", load_data, 32'h1234_AA78); nxt;

        // SH 0x0A followed immediately by SB 0x08
        mem[2] = 32'h1234_5678;
        req(1'b0, 1'b1, 3'b001, 32'hA, 32'h0000_BEEF);
        mid; chk("sh_stall", {31'h0, stall}, 32'h1); nxt;
        mid; chk("sh_wd", dm_wd, 32'hBEEF_5678); chk("sh_we", {31'h0, dm_we}, 32'h1); nxt;
        req(1'b0, 1'b1, 3'b000, 32'h8, 32'h0000_0011);
        mid; chk("sb2_stall", {31'h0, stall}, 32'h1); nxt;
        mid; chk("sb2_wd", dm_wd, 32'hBEEF_5611); nxt;
        req(1'b1, 1'b0, 3'b010, 32'h8, 32'h0); mid; chk("lw8_sh", load_data, 32'hBEEF_5611); nxt;

        // Faults
        req(1'b1, 1'b0, 3'b010, 32'h6, 32'h0);
        mid;
        chk("lw6_fault",   {31'h0, fault}, 32'h1);
        chk("lw6_ld",      load_data, 32'h0);
        chk("lw6_sticky0", {31'h0, fault_sticky}, 32'h0);
        nxt;
        chk("lw6_sticky1", {31'h0, fault_sticky}, 32'h1);
        req(1'b0, 1'b1, 3'b001, 32'h3, 32'h0000_1234);
        mid;
        chk("sh3_fault", {31'h0, fault}, 32'h1);
        chk("sh3_we",    {31'h0, dm_we}, 32'h0);
        chk("sh3_stall", {31'h0, stall}, 32'h0);
        nxt;
        chk("sh3_sticky", {31'h0, fault_sticky}, 32'h1);
        req(1'b1, 1'b0, 3'b011, 32'h0, 32'h0); mid; chk("f3_011_fault", {31'h0, fault}, 32'h1); nxt;
        req(1'b0, 1'b1, 3'b100, 32'h0, 32'h0); mid; chk("sbu_fault", {31'h0, fault}, 32'h1);
        chk("sbu_we", {31'h0, dm_we}, 32'h0); nxt;
        req(1'b0, 1'b1, 3'b010, 32'h2, 32'h0); mid; chk("sw2_fault", {31'h0, fault}, 32'h1);
        chk("sw2_we", {31'h0, dm_we}, 32'h0); nxt;
        req(1'b1, 1'b0, 3'b001, 32'h2, 32'h0); mid; chk("lh2_ok", {31'h0, fault}, 32'h0); nxt;

        // Reset during WRITE drops the pending SB
        mem[3] = 32'h5566_7788;
        req(1'b0, 1'b1, 3'b000, 32'hC, 32'h0000_0099);
        mid; chk("sbc_stall", {31'h0, stall}, 32'h1); nxt;
        rst_n = 1'b0;
        mid;
        chk("rstw_we",    {31'h0, dm_we}, 32'h0);
        chk("rstw_stall", {31'h0, stall}, 32'h0);
        nxt;
        chk("rstw_mem",    mem[3], 32'h5566_7788);
        chk("rstw_sticky", {31'h0, fault_sticky}, 32'h0);
        rst_n = 1'b1;
        req(1'b1, 1'b0, 3'b010, 32'hC, 32'h0);
        mid;
        chk("lwc",       load_data, 32'h5566_7788);
        chk("lwc_we",    {31'h0, dm_we}, 32'h0);
        chk("lwc_stall", {31'h0, stall}, 32'h0);
        nxt;

        // Read and write together behaves as a store
        req(1'b1, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D);
        mid;
        chk("rw_ld", load_data, 32'h0);
        chk("rw_we", {31'h0, dm_we}, 32'h1);
        nxt;
        req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0); mid; chk("lw10", load_data, 32'hCAFE_F00D); nxt;

        req(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        nxt;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit sitting directly upstream of `data_memory` in the RISC-V pipeline. It converts MEM-stage load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-wide accesses on the `data_memory` port (`we`, `addr`, `wd`, `rd`). Loads are extracted and sign- or zero-extended. Because `data_memory` has no byte enables, SB and SH run a two-cycle read-modify-write sequence that stalls the pipeline for one cycle.

## Interface
- `ADDR_W`, 32: address width. Data width is fixed at 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mem_read`  in  1  MEM-stage load request.
- `mem_write`  in  1  MEM-stage store request.
- `funct3`  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `addr`  in  ADDR_W  byte address from the ALU.
- `store_data`  in  32  rs2 value; the low byte or half is used for SB/SH.
- `load_data`  out  32  extended load result.
- `stall`  out  1  hold IF/ID/EX/MEM registers this cycle.
- `fault`  out  1  current request is misaligned or illegal (combinational).
- `fault_sticky`  out  1  latched OR of `fault`, cleared only by reset.
- `dm_we`  out  1  to `data_memory.we`.
- `dm_addr`  out  ADDR_W  to `data_memory.addr`, always `{addr[ADDR_W-1:2],2'b00}` (latched address in WRITE).
- `dm_wd`  out  32  to `data_memory.wd`.
- `dm_rd`  in  32  from `data_memory.rd`; combinational read of `dm_addr`.

## Operation
- FSM states: IDLE and WRITE. Registers: `state`, `wr_addr` (word address), `merge` (32b), `fault_sticky`.
- Request types:
  - Store = `mem_write`.
  - Load = `mem_read & ~mem_write`.
  - If both `mem_read` and `mem_write` are high, the request is treated as a store and `load_data` = 0.
- Fault:
  - Illegal funct3: 011/110/111 for loads; anything other than 000/001/010 for stores.
  - Misaligned: H/HU/SH with `addr[0]`=1; W/SW with `addr[1:0]`≠0.
  - On fault: no write, `load_data` = 0, no stall, `fault`=1 for that cycle, `fault_sticky` set on the next edge.
- Loads (IDLE):
  - Byte lane selected by `addr[1:0]`; half lane selected by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes `dm_rd` through.
  - Zero-cycle latency, no stall.
- SW (IDLE, aligned): `dm_we`=1, `dm_wd`=`store_data` in the same cycle, no stall.
- SB/SH (IDLE, aligned):
  - `stall`=1, `dm_we`=0.
  - At the edge: `merge` ← `dm_rd` with the target lane replaced by `store_data[7:0]` or `store_data[15:0]`; `wr_addr` ← word address; go to WRITE.
- WRITE:
  - `dm_we`=1, `dm_addr`=`wr_addr`, `dm_wd`=`merge`, `stall`=0.
  - Current inputs are ignored (they still hold the same instruction).
  - Always returns to IDLE at the next edge.
- No request: `dm_we`=0, `load_data`=0, `stall`=0.
- Reset:
  - Asserting `rst_n` low at any time, including in WRITE, forces IDLE and clears `merge`, `wr_addr` and `fault_sticky`.
  - A pending SB/SH write is dropped: no `dm_we` pulse.
  - While `rst_n`=0: `dm_we`=0, `stall`=0, `fault`=0, `load_data`=0.

## Timing
- Load: result is valid combinationally in the cycle the request is presented (through `dm_rd`).
- SW: memory updated at the rising edge ending the request cycle.
- SB/SH: cycle N is IDLE with `stall`=1 (read); cycle N+1 is WRITE with `dm_we`=1. Memory is updated at the edge ending N+1, and the pipeline advances at that same edge.
- Back-to-back stores: a store arriving in the cycle after WRITE is decoded normally from IDLE. The read in that cycle sees the just-written word, because the write completed at the prior edge.
- `fault_sticky` rises at the edge ending the faulting cycle.

## Test plan
- Reset, then SW `addr`=0x04 `store_data`=0xDEADBEEF; then LW 0x04 → `load_data`=0xDEADBEEF. Then LB 0x07 → 0xFFFFFFDE; LBU 0x07 → 0x000000DE; LH 0x06 → 0xFFFFDEAD.
- Word 0x08=0x12345678; SB 0x09 `store_data`=0xAA → `stall`=1 for one cycle, then one `dm_we` pulse with `dm_wd`=0x1234AA78; LW 0x08 → 0x1234AA78.
- SH 0x0A `store_data`=0xBEEF on word 0x12345678 → write 0xBEEF5678. An immediately following SB 0x08 0x11 → write 0xBEEF5611.
- LW 0x06 → `fault`=1, `load_data`=0. SH 0x03 → no `dm_we`, no stall, `fault_sticky`=1 afterwards. funct3=011 load → `fault`=1.
- Pull `rst_n` low during the WRITE cycle of SB 0x0C → no `dm_we` pulse, state IDLE, LW 0x0C returns the unchanged value.
- `mem_read`=`mem_write`=1 with SW 0x10 `store_data`=0xCAFEF00D → treated as a store, `load_data`=0; LW 0x10 → 0xCAFEF00D.
